// File: rtl/bram_burst_if.sv
// Command / write-stream / read-stream bundle for the burst BRAM controller.
// The master issues commands and write beats; the slave returns read beats and status.
interface bram_burst_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_last;
  logic              busy;
  logic              done;

  modport master (
    output cmd_valid, cmd_wr, cmd_addr, cmd_len, wr_data, wr_valid,
    input  cmd_ready, wr_ready, rd_data, rd_valid, rd_last, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len, wr_data, wr_valid,
    output cmd_ready, wr_ready, rd_data, rd_valid, rd_last, busy, done
  );
endinterface

// File: rtl/bram_burst_ctrl.sv
// Single-port block-RAM controller with write/read bursts.
// RAM port signals are registered, so beat k's address sits on the RAM port in
// cycle T+1+k after the accept edge T; read data then walks through RD_LAT stages
// (RAM output register plus RD_LAT-1 extra registers) with a matching valid/last pipe.
module bram_burst_ctrl #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  bram_burst_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  cnt;

  // Registered RAM port
  logic              ram_we;
  logic              ram_re;
  logic              ram_last;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              wr_done;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Read pipeline: stage 0 is the RAM output register
  logic [RD_LAT-1:0] vpipe;
  logic [RD_LAT-1:0] lpipe;
  logic [DATA_W-1:0] dpipe [RD_LAT];

  // Command acceptance, address/beat sequencing and RAM port registers
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignment so every register samples
    // pre-edge values; blocking would make later statements see updated values.
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      len       <= '0;
      cnt       <= '0;
      ram_we    <= 1'b0;
      ram_re    <= 1'b0;
      ram_last  <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      wr_done   <= 1'b0;
    end else begin
      ram_we   <= 1'b0;
      ram_re   <= 1'b0;
      ram_last <= 1'b0;
      wr_done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            addr  <= bus.cmd_addr;
            len   <= bus.cmd_len;
            cnt   <= '0;
            state <= bus.cmd_wr ? WRITE : READ;
          end
        end
        WRITE: begin
          if (bus.wr_valid) begin
            ram_we    <= 1'b1;
            ram_addr  <= addr;
            ram_wdata <= bus.wr_data;
            addr      <= addr + ADDR_W'(1);
            cnt       <= cnt + LEN_W'(1);
            if (cnt == len) begin
              state   <= IDLE;
              wr_done <= 1'b1;
            end
          end
        end
        READ: begin
          ram_re   <= 1'b1;
          ram_addr <= addr;
          ram_last <= (cnt == len);
          addr     <= addr + ADDR_W'(1);
          cnt      <= cnt + LEN_W'(1);
          if (cnt == len) state <= DRAIN;
        end
        DRAIN: begin
          if (vpipe[RD_LAT-1] && lpipe[RD_LAT-1]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM array write port
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; clearing it would prevent block-RAM
    // inference, and contents must survive a controller reset anyway.
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  // Read data pipeline; each data stage only loads on a valid beat so rd_data holds
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vpipe <= '0;
      lpipe <= '0;
      for (int i = 0; i < RD_LAT; i++) dpipe[i] <= '0;
    end else begin
      vpipe[0] <= ram_re;
      lpipe[0] <= ram_re & ram_last;
      if (ram_re) dpipe[0] <= mem[ram_addr];
      for (int i = 1; i < RD_LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
        lpipe[i] <= lpipe[i-1];
        if (vpipe[i-1]) dpipe[i] <= dpipe[i-1];
      end
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.wr_ready  = (state == WRITE);
  assign bus.busy      = (state != IDLE);
  assign bus.rd_valid  = vpipe[RD_LAT-1];
  assign bus.rd_last   = lpipe[RD_LAT-1];
  assign bus.rd_data   = dpipe[RD_LAT-1];
  assign bus.done      = wr_done | (vpipe[RD_LAT-1] & lpipe[RD_LAT-1]);

endmodule

// File: tb/tb_bram_burst_ctrl.sv
// Directed bench for bram_burst_ctrl: default build (RD_LAT=2, 64-bit) plus a
// second instance with RD_LAT=4, DATA_W=32 for the single-beat latency case.
module tb_bram_burst_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bram_burst_if #(.DATA_W(64), .ADDR_W(10), .LEN_W(8)) bus ();
  bram_burst_if #(.DATA_W(32), .ADDR_W(10), .LEN_W(8)) bus2 ();

  bram_burst_ctrl #(.DATA_W(64), .ADDR_W(10), .LEN_W(8), .RD_LAT(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  bram_burst_ctrl #(.DATA_W(32), .ADDR_W(10), .LEN_W(8), .RD_LAT(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  // Observations of one read burst on bus
  logic [63:0] got_data[$];
  int          got_cyc[$];
  bit          got_last[$];
  bit          got_done[$];
  int          got_stray;
  int          got_ready_hi;
  bit          got_timeout;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_burst(input logic [9:0] a, input logic [7:0] l, input logic [63:0] d0);
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    tick;
    bus.cmd_valid = 1'b0;
    for (int i = 0; i <= int'(l); i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = d0 + 64'(i);
      tick;
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic start_read(input logic [9:0] a, input logic [7:0] l);
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = 1'b0;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    tick;
    bus.cmd_valid = 1'b0;
  endtask

  // Record read beats (cycle offset from the accept edge) until rd_last or budget
  task automatic collect;
    got_data.delete();
    got_cyc.delete();
    got_last.delete();
    got_done.delete();
    got_stray    = 0;
    got_ready_hi = 0;
    got_timeout  = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick;
      if (bus.cmd_ready === 1'b1) got_ready_hi++;
      if (bus.rd_valid === 1'b1) begin
        got_data.push_back(bus.rd_data);
        got_cyc.push_back(c);
        got_last.push_back(bus.rd_last === 1'b1);
        got_done.push_back(bus.done === 1'b1);
        if (bus.rd_last === 1'b1) begin
          got_timeout = 1'b0;
          break;
        end
      end else if (bus.done === 1'b1 || bus.rd_last === 1'b1) begin
        got_stray++;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    checks++;
    if ({bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.rd_last, bus.busy, bus.done} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_flags: got %b, need 100000",
               {bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.rd_last, bus.busy, bus.done});
    end
    checks++;
    if (bus.rd_data !== 64'h0) begin
      errors++;
      $display("FAIL reset_rd_data: got %h, need 0", bus.rd_data);
    end
    checks++;
    if ({bus2.cmd_ready, bus2.rd_valid, bus2.busy, bus2.done, bus2.rd_data} !== {4'b1000, 32'h0}) begin
      errors++;
      $display("FAIL reset_dut2: got %b/%h, need 1000/0",
               {bus2.cmd_ready, bus2.rd_valid, bus2.busy, bus2.done}, bus2.rd_data);
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    logic [73:0] o, e;
    write_burst(10'h010, 8'd3, 64'hA0);
    checks++;
    if ({bus.done, bus.busy, bus.cmd_ready} !== 3'b101) begin
      errors++;
      $display("FAIL basic_wr_done: got done/busy/ready %b, need 101", {bus.done, bus.busy, bus.cmd_ready});
    end
    tick;
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_width: got %b, need 0", bus.done);
    end
    start_read(10'h010, 8'd3);
    collect;
    checks++;
    if (got_timeout || got_stray != 0 || got_data.size() != 4) begin
      errors++;
      $display("FAIL basic_beats: got %0d beats stray=%0d timeout=%0b, need 4 0 0",
               got_data.size(), got_stray, got_timeout);
    end
    for (int i = 0; i < got_data.size() && i < 4; i++) begin
      o = {got_data[i], 8'(got_cyc[i]), got_last[i], got_done[i]};
      e = {64'hA0 + 64'(i), 8'(3 + i), i == 3, i == 3};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL basic_beat%0d: got data/cyc/last/done %h, need %h", i, o, e);
      end
    end
    tick;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready_after: got %b, need 1", bus.cmd_ready);
    end
  endtask

  task automatic test_stall;
    logic [73:0] o, e;
    logic [63:0] exp_d [3];
    exp_d = '{64'hB0, 64'hB1, 64'h5502};
    write_burst(10'h020, 8'd2, 64'h5500);
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = 1'b1;
    bus.cmd_addr  = 10'h020;
    bus.cmd_len   = 8'd1;
    tick;
    bus.cmd_valid = 1'b0;
    bus.wr_valid  = 1'b1;
    bus.wr_data   = 64'hB0;
    tick;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = 64'hEE;
    for (int g = 0; g < 3; g++) begin
      tick;
      checks++;
      if ({bus.busy, bus.wr_ready, bus.done} !== 3'b110) begin
        errors++;
        $display("FAIL stall_gap%0d: got busy/wr_ready/done %b, need 110", g,
                 {bus.busy, bus.wr_ready, bus.done});
      end
    end
    bus.wr_valid = 1'b1;
    bus.wr_data  = 64'hB1;
    tick;
    bus.wr_valid = 1'b0;
    checks++;
    if ({bus.done, bus.busy} !== 2'b10) begin
      errors++;
      $display("FAIL stall_done: got done/busy %b, need 10", {bus.done, bus.busy});
    end
    start_read(10'h020, 8'd2);
    collect;
    checks++;
    if (got_timeout || got_stray != 0 || got_data.size() != 3) begin
      errors++;
      $display("FAIL stall_beats: got %0d beats stray=%0d timeout=%0b, need 3 0 0",
               got_data.size(), got_stray, got_timeout);
    end
    for (int i = 0; i < got_data.size() && i < 3; i++) begin
      o = {got_data[i], 8'(got_cyc[i]), got_last[i], got_done[i]};
      e = {exp_d[i], 8'(3 + i), i == 2, i == 2};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL stall_beat%0d: got data/cyc/last/done %h, need %h", i, o, e);
      end
    end
    tick;
  endtask

  task automatic test_wrap;
    write_burst(10'h3FE, 8'd3, 64'hC0);
    tick;
    start_read(10'h3FE, 8'd3);
    collect;
    checks++;
    if (got_timeout || got_data.size() != 4) begin
      errors++;
      $display("FAIL wrap_beats: got %0d beats timeout=%0b, need 4 0", got_data.size(), got_timeout);
    end
    for (int i = 0; i < got_data.size() && i < 4; i++) begin
      checks++;
      if ({got_data[i], got_last[i]} !== {64'hC0 + 64'(i), i == 3}) begin
        errors++;
        $display("FAIL wrap_beat%0d: got %h last=%0b, need %h last=%0b", i, got_data[i],
                 got_last[i], 64'hC0 + 64'(i), i == 3);
      end
    end
    tick;
    start_read(10'h000, 8'd1);
    collect;
    checks++;
    if (got_timeout || got_data.size() != 2) begin
      errors++;
      $display("FAIL wrap_low_beats: got %0d beats timeout=%0b, need 2 0", got_data.size(), got_timeout);
    end else if (got_data[0] !== 64'hC2 || got_data[1] !== 64'hC3) begin
      errors++;
      $display("FAIL wrap_low_data: got %h %h, need c2 c3", got_data[0], got_data[1]);
    end
    tick;
  endtask

  task automatic test_cmd_while_busy;
    start_read(10'h010, 8'd3);
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = 1'b1;
    bus.cmd_addr  = 10'h010;
    bus.cmd_len   = 8'd0;
    collect;
    checks++;
    if (got_ready_hi != 0) begin
      errors++;
      $display("FAIL busy_cmd_ready: got ready high %0d cycles, need 0", got_ready_hi);
    end
    checks++;
    if (got_timeout || got_stray != 0 || got_data.size() != 4) begin
      errors++;
      $display("FAIL busy_beats: got %0d beats stray=%0d timeout=%0b, need 4 0 0",
               got_data.size(), got_stray, got_timeout);
    end
    for (int i = 0; i < got_data.size() && i < 4; i++) begin
      checks++;
      if ({got_data[i], 8'(got_cyc[i]), got_done[i]} !== {64'hA0 + 64'(i), 8'(3 + i), i == 3}) begin
        errors++;
        $display("FAIL busy_beat%0d: got %h cyc=%0d done=%0b, need %h cyc=%0d", i, got_data[i],
                 got_cyc[i], got_done[i], 64'hA0 + 64'(i), 3 + i);
      end
    end
    tick;
    checks++;
    if ({bus.cmd_ready, bus.busy} !== 2'b10) begin
      errors++;
      $display("FAIL busy_after_done: got ready/busy %b, need 10", {bus.cmd_ready, bus.busy});
    end
    tick;
    bus.cmd_valid = 1'b0;
    checks++;
    if ({bus.wr_ready, bus.busy} !== 2'b11) begin
      errors++;
      $display("FAIL busy_second_accept: got wr_ready/busy %b, need 11", {bus.wr_ready, bus.busy});
    end
    bus.wr_valid = 1'b1;
    bus.wr_data  = 64'hD0;
    tick;
    bus.wr_valid = 1'b0;
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL busy_second_done: got %b, need 1", bus.done);
    end
    tick;
  endtask

  task automatic test_reset_mid_read;
    logic [63:0] exp_d [4];
    exp_d = '{64'hD0, 64'hA1, 64'hA2, 64'hA3};
    start_read(10'h011, 8'd2);
    tick;
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    checks++;
    if ({bus.rd_valid, bus.done, bus.busy, bus.cmd_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL rstmid_flags: got valid/done/busy/ready %b, need 0001",
               {bus.rd_valid, bus.done, bus.busy, bus.cmd_ready});
    end
    for (int c = 0; c < 5; c++) begin
      tick;
      checks++;
      if ({bus.rd_valid, bus.done, bus.busy} !== 3'b000) begin
        errors++;
        $display("FAIL rstmid_quiet%0d: got valid/done/busy %b, need 000", c,
                 {bus.rd_valid, bus.done, bus.busy});
      end
    end
    start_read(10'h010, 8'd3);
    collect;
    checks++;
    if (got_timeout || got_data.size() != 4) begin
      errors++;
      $display("FAIL rstmid_beats: got %0d beats timeout=%0b, need 4 0", got_data.size(), got_timeout);
    end
    for (int i = 0; i < got_data.size() && i < 4; i++) begin
      checks++;
      if (got_data[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL rstmid_beat%0d: got %h, need %h", i, got_data[i], exp_d[i]);
      end
    end
    tick;
  endtask

  task automatic test_lat4_single;
    bus2.cmd_valid = 1'b1;
    bus2.cmd_wr    = 1'b1;
    bus2.cmd_addr  = 10'h005;
    bus2.cmd_len   = 8'd0;
    tick;
    bus2.cmd_valid = 1'b0;
    bus2.wr_valid  = 1'b1;
    bus2.wr_data   = 32'hCAFE0001;
    tick;
    bus2.wr_valid  = 1'b0;
    checks++;
    if (bus2.done !== 1'b1) begin
      errors++;
      $display("FAIL lat4_wr_done: got %b, need 1", bus2.done);
    end
    tick;
    bus2.cmd_valid = 1'b1;
    bus2.cmd_wr    = 1'b0;
    bus2.cmd_addr  = 10'h005;
    tick;
    bus2.cmd_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick;
      checks++;
      if ({bus2.rd_valid, bus2.rd_last, bus2.done} !== ((c == 5) ? 3'b111 : 3'b000)) begin
        errors++;
        $display("FAIL lat4_cyc%0d: got valid/last/done %b, need %b", c,
                 {bus2.rd_valid, bus2.rd_last, bus2.done}, (c == 5) ? 3'b111 : 3'b000);
      end
      if (c == 5) begin
        checks++;
        if (bus2.rd_data !== 32'hCAFE0001) begin
          errors++;
          $display("FAIL lat4_data: got %h, need cafe0001", bus2.rd_data);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_wr     = 1'b0;
    bus.cmd_addr   = '0;
    bus.cmd_len    = '0;
    bus.wr_data    = '0;
    bus.wr_valid   = 1'b0;
    bus2.cmd_valid = 1'b0;
    bus2.cmd_wr    = 1'b0;
    bus2.cmd_addr  = '0;
    bus2.cmd_len   = '0;
    bus2.wr_data   = '0;
    bus2.wr_valid  = 1'b0;
    test_reset;
    test_basic;
    test_stall;
    test_wrap;
    test_cmd_while_busy;
    test_reset_mid_read;
    test_lat4_single;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_burst_ctrl.md
Name: bram_burst_ctrl

Overview:
- Parametrised single-port block-RAM controller with burst support and aligned read-valid tracking.
- Accepts one command at a time (write burst or read burst) and generates sequential addresses.
- Streams write data in with a valid/ready handshake; streams read data out with valid/last flags aligned to a configurable read latency.
- Sits between feature-extraction stages and on-chip buffer storage, replacing fixed-width, fixed-latency RAM wrappers.

Parameters:
DATA_W, 64, data word width in bits
ADDR_W, 10, address width; depth = 2^ADDR_W words
LEN_W, 8, burst length field width; max burst = 2^LEN_W beats
RD_LAT, 2, cycles from address issue to rd_valid; must be >= 1. The RAM output register is stage 1; stages 2..RD_LAT are extra pipeline registers.

Ports:
clk  in  1  sole clock, all logic on rising edge
rst_n  in  1  synchronous reset, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_wr  in  1  1 = write burst, 0 = read burst
cmd_addr  in  ADDR_W  burst base address
cmd_len  in  LEN_W  beats minus 1 (0 = 1 beat)
wr_data  in  DATA_W  write beat data
wr_valid  in  1  write beat present
wr_ready  out  1  high in WRITE state
rd_data  out  DATA_W  read beat data
rd_valid  out  1  read beat valid, single cycle per beat
rd_last  out  1  with rd_valid on final beat of burst
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at burst completion

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE; address counter and beat counter go to 0; valid/last pipeline cleared.
  - Reset output values: cmd_ready=1 (after reset), wr_ready=0, rd_valid=0, rd_last=0, busy=0, done=0, rd_data=0.
  - RAM contents are not cleared.
  - Reset mid-burst aborts the burst. In-flight read beats are discarded and done is not pulsed.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - On cmd_valid=1, the command is accepted at edge T. Addr and len are latched and the beat counter is set to 0.
  - The next state is WRITE if cmd_wr=1, otherwise READ.
  - cmd_valid while not in IDLE is ignored: cmd_ready=0 and no queueing.
- WRITE:
  - wr_ready=1.
  - Each cycle with wr_valid=1 writes wr_data to the current address, then increments the address and the beat counter.
  - If wr_valid=0, the controller stalls and holds state, address and counter.
  - On the beat where counter==len, the write completes. The next state is IDLE and done pulses in the following cycle (T_last+1).
- READ:
  - Issues one address per cycle with no stall (there is no rd backpressure).
  - Beat k's address is presented at cycle T+1+k. The matching rd_valid and rd_data appear at cycle T+1+k+RD_LAT.
  - A valid/last shift register of depth RD_LAT runs alongside the data.
  - After the last address is issued, the next state is DRAIN.
- DRAIN:
  - Waits until the pipeline is empty.
  - done pulses in the same cycle as the final rd_valid/rd_last, and the next state is IDLE.
  - cmd_ready rises the cycle after done.
- Addressing:
  - Address increments modulo 2^ADDR_W, so a burst crossing the top address wraps to 0 with no error.
  - The beat counter is LEN_W wide. cmd_len=2^LEN_W-1 gives a full-length burst.
- RAM:
  - Inferred single-port RAM with a registered output; no vendor IP.
  - No read and write in the same cycle, because the controller is single-mode.
- rd_data holds its last value when rd_valid=0.
- Throughput: a read burst of N beats takes 1+N+RD_LAT cycles from accept to done. A write burst with continuous wr_valid takes N cycles plus 1 for done.

Test Plan:
1. Reset, then write burst addr=0x010, len=3 with data 0xA0..0xA3 and continuous wr_valid; then read the same burst. Required: rd_valid on 4 consecutive cycles starting 3 cycles after the READ entry edge (RD_LAT=2), data 0xA0..0xA3, rd_last on 0xA3, done coincident with it.
2. Write burst len=1 with wr_valid deasserted for 3 cycles between beats. Required: only 2 RAM writes occur and address holds during the gap; readback returns both words at consecutive addresses.
3. Wrap: write addr=0x3FE, len=3 (ADDR_W=10). Required: words land at 0x3FE, 0x3FF, 0x000, 0x001; readback from 0x3FE returns them in order.
4. Hold cmd_valid=1 with a different command during an active read burst. Required: cmd_ready=0 and the second command is ignored; the original read data is unchanged; the new command is accepted only after the done cycle.
5. Assert rst_n=0 for one cycle while 2 read beats are in flight. Required: rd_valid=0 from the next cycle, no done pulse, busy=0, cmd_ready=1. Previously written RAM data is still readable afterwards.
6. Rebuild with RD_LAT=4, DATA_W=32, and read a single beat (len=0). Required: rd_valid exactly 5 cycles after the accept edge, rd_last=1, done=1 in the same cycle.
